// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 draw engine: FSM state encoding,
// default display geometry and the memory address width.
package chip8_pkg;

   localparam int DISP_W_DEF = 64;
   localparam int DISP_H_DEF = 32;
   localparam int ADDR_W     = 12;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      XOR,
      DONE
   } state_t;

endpackage

// File: rtl/chip8_row_xor.sv
// Combinational XOR of one 8-pixel sprite slice into the existing pixels.
// Ports:
//   old_px  - current pixels, bit k = pixel x0+k
//   sprite  - sprite bits in the same pixel order (clipped pixels already 0)
//   new_px  - updated pixels
//   hit     - 1 when any lit pixel is turned off
module chip8_row_xor (
   input  logic [7:0] old_px,
   input  logic [7:0] sprite,
   output logic [7:0] new_px,
   output logic       hit
);

   assign new_px = old_px ^ sprite;
   assign hit    = |(old_px & sprite);

endmodule

// File: rtl/chip8_draw_engine.sv
// CHIP-8 DXYN sprite draw / 00E0 clear engine with an on-chip framebuffer.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   start, clear       - draw / clear request strobes, accepted only in IDLE
//   vx, vy, n, i_reg   - draw coordinates, sprite height, sprite base address
//   mem_rd_en/mem_addr - sprite memory read request, data on mem_data one cycle later
//   busy, done         - engine active / one-cycle completion pulse
//   collision          - VF result of the last draw
//   display            - framebuffer, bit index = y*DISP_W + x
// Build option: define CHIP8_DRAW_WRAP_EN to wrap pixels past the right or
// bottom edge; by default such pixels are clipped.
//
// state | meaning
// IDLE  | waiting for start or clear
// READ  | issue sprite byte read for current row
// XOR   | merge returned byte into framebuffer row
// DONE  | draw finished, done pulses next cycle
module chip8_draw_engine
   import chip8_pkg::*;
#(
   parameter int DISP_W = DISP_W_DEF,
   parameter int DISP_H = DISP_H_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     clear,
   input  logic [7:0]               vx,
   input  logic [7:0]               vy,
   input  logic [3:0]               n,
   input  logic [11:0]              i_reg,
   output logic                     mem_rd_en,
   output logic [11:0]              mem_addr,
   input  logic [7:0]               mem_data,
   output logic                     busy,
   output logic                     done,
   output logic                     collision,
   output logic [DISP_W*DISP_H-1:0] display
);

   localparam int IDX_W = $clog2(DISP_W * DISP_H);

   state_t                  state_q, state_d;
   logic [7:0]              x0_q, y0_q;
   logic [3:0]              n_q, row_q;
   logic [ADDR_W-1:0]       base_q;
   logic                    done_q, coll_q;
   logic [DISP_W*DISP_H-1:0] fb_q;

   logic             accept_start, do_clear, last_row;
   logic             row_ok;
   int               py, px;
   logic [IDX_W-1:0] pix_idx [8];
   logic [7:0]       pix_ok, old_px, sprite_px, new_px;
   logic             hit;

   assign accept_start = (state_q == IDLE) && start;
   assign do_clear     = (state_q == IDLE) && clear && !start;
   assign last_row     = ({1'b0, row_q} + 5'd1) >= {1'b0, n_q};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (n == 4'd0) ? DONE : READ;
         READ:    state_d = XOR;
         XOR:     state_d = last_row ? DONE : READ;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pixel k of the current row comes from sprite bit 7-k.
   always_comb begin
      py     = int'(y0_q) + int'(row_q);
      px     = 0;
      row_ok = 1'b1;
      pix_ok    = '0;
      old_px    = '0;
      sprite_px = '0;
      for (int k = 0; k < 8; k++) pix_idx[k] = '0;
`ifdef CHIP8_DRAW_WRAP_EN
      py = py % DISP_H;
`else
      if (py >= DISP_H) row_ok = 1'b0;
`endif
      for (int k = 0; k < 8; k++) begin
         px = int'(x0_q) + k;
`ifdef CHIP8_DRAW_WRAP_EN
         px        = px % DISP_W;
         pix_ok[k] = 1'b1;
`else
         pix_ok[k] = row_ok && (px < DISP_W);
`endif
         if (pix_ok[k]) begin
            pix_idx[k]   = IDX_W'(py * DISP_W + px);
            old_px[k]    = fb_q[pix_idx[k]];
            sprite_px[k] = mem_data[7-k];
         end
      end
   end

   chip8_row_xor u_row_xor (
      .old_px (old_px),
      .sprite (sprite_px),
      .new_px (new_px),
      .hit    (hit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         n_q     <= '0;
         row_q   <= '0;
         base_q  <= '0;
         done_q  <= 1'b0;
         coll_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == DONE) || do_clear;
         if (accept_start) begin
            x0_q   <= 8'(int'(vx) % DISP_W);
            y0_q   <= 8'(int'(vy) % DISP_H);
            n_q    <= n;
            base_q <= i_reg;
            row_q  <= '0;
            coll_q <= 1'b0;
         end else if (state_q == XOR) begin
            row_q <= row_q + 4'd1;
            if (hit) coll_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || do_clear) begin
         fb_q <= '0;
      end else if (state_q == XOR) begin
         for (int k = 0; k < 8; k++)
            if (pix_ok[k]) fb_q[pix_idx[k]] <= new_px[k];
      end
   end

   assign mem_rd_en = (state_q == READ);
   assign mem_addr  = base_q + ADDR_W'(row_q);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign collision = coll_q;
   assign display   = fb_q;

endmodule

// File: tb/tb_chip8_draw_engine.sv
// Directed self-checking bench for chip8_draw_engine (default 64x32 display).
module tb_chip8_draw_engine;

   logic          clk = 1'b0;
   logic          reset, start, clear;
   logic [7:0]    vx, vy;
   logic [3:0]    n;
   logic [11:0]   i_reg;
   logic          mem_rd_en;
   logic [11:0]   mem_addr;
   logic [7:0]    mem_data;
   logic          busy, done, collision;
   logic [2047:0] display;
   logic [2047:0] exp_disp;

   logic [7:0]  mem [4096];
   logic [11:0] rd_log [256];
   int          rd_cnt = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   int          lat, base, cnt_done, cnt_busy;

   chip8_draw_engine dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .clear     (clear),
      .vx        (vx),
      .vy        (vy),
      .n         (n),
      .i_reg     (i_reg),
      .mem_rd_en (mem_rd_en),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .busy      (busy),
      .done      (done),
      .collision (collision),
      .display   (display)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_data               <= mem[mem_addr];
         rd_log[rd_cnt & 255]   <= mem_addr;
         rd_cnt                 <= rd_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic set_px(input int x, input int y);
      exp_disp[y*64 + x] = 1'b1;
   endtask

   task automatic do_draw(input logic [7:0] ax, input logic [7:0] ay, input logic [3:0] an,
                          input logic [11:0] ai, output int l);
      @(negedge clk);
      vx = ax; vy = ay; n = an; i_reg = ai; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("busy_after_start", busy, 1);
      l = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            l = k;
            break;
         end
      end
      @(posedge clk);
      #1;
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      chk("clr_done", done, 1);
      chk("clr_busy", busy, 0);
      chk("clr_disp", $countones(display), 0);
      @(posedge clk);
      #1;
      chk("clr_done_drop", done, 0);
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
      mem[12'h300] = 8'hF0;
      mem[12'h310] = 8'hFF;
      mem[12'h311] = 8'hFF;
      mem[12'hFFF] = 8'h80;
      mem[12'h000] = 8'h01;
      for (int a = 0; a < 15; a++) mem[12'h330 + a] = 8'hFF;
      mem[12'h320] = 8'h81;
      mem[12'h321] = 8'h42;
      mem[12'h322] = 8'h24;

      reset = 1'b1; start = 1'b0; clear = 1'b0;
      vx = '0; vy = '0; n = '0; i_reg = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_disp", $countones(display), 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_coll", collision, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_addr", mem_addr, 0);

      do_clear();

      // single row at origin
      base = rd_cnt;
      do_draw(8'd0, 8'd0, 4'd1, 12'h300, lat);
      exp_disp = '0;
      for (int x = 0; x < 4; x++) set_px(x, 0);
      chk("d1_latency", lat, 3);
      chk("d1_disp", $countones(display ^ exp_disp), 0);
      chk("d1_coll", collision, 0);
      chk("d1_reads", rd_cnt - base, 1);
      chk("d1_addr", rd_log[base & 255], 12'h300);

      // same draw erases and collides
      do_draw(8'd0, 8'd0, 4'd1, 12'h300, lat);
      chk("d2_latency", lat, 3);
      chk("d2_disp", $countones(display), 0);
      chk("d2_coll", collision, 1);

      // n=0: no reads, collision cleared by the start
      base = rd_cnt;
      do_draw(8'd5, 8'd5, 4'd0, 12'h123, lat);
      chk("n0_latency", lat, 1);
      chk("n0_reads", rd_cnt - base, 0);
      chk("n0_coll", collision, 0);
      chk("n0_disp", $countones(display), 0);

      // bottom-right corner
      base = rd_cnt;
      do_draw(8'd62, 8'd31, 4'd2, 12'h310, lat);
      exp_disp = '0;
      set_px(62, 31); set_px(63, 31);
`ifdef CHIP8_DRAW_WRAP_EN
      for (int x = 0; x < 6; x++) set_px(x, 31);
      set_px(62, 0); set_px(63, 0);
      for (int x = 0; x < 6; x++) set_px(x, 0);
`endif
      chk("edge_latency", lat, 5);
      chk("edge_disp", $countones(display ^ exp_disp), 0);
      chk("edge_coll", collision, 0);
      chk("edge_reads", rd_cnt - base, 2);
      chk("edge_addr0", rd_log[base & 255], 12'h310);
      chk("edge_addr1", rd_log[(base + 1) & 255], 12'h311);

      do_clear();

      // start coordinates wrap, address wraps past 0xFFF
      base = rd_cnt;
      do_draw(8'd70, 8'd40, 4'd2, 12'hFFF, lat);
      exp_disp = '0;
      set_px(6, 8);
      set_px(13, 9);
      chk("wrap_latency", lat, 5);
      chk("wrap_disp", $countones(display ^ exp_disp), 0);
      chk("wrap_reads", rd_cnt - base, 2);
      chk("wrap_addr0", rd_log[base & 255], 12'hFFF);
      chk("wrap_addr1", rd_log[(base + 1) & 255], 12'h000);

      do_clear();

      // reset in the middle of an n=15 draw
      @(negedge clk);
      vx = 8'd0; vy = 8'd0; n = 4'd15; i_reg = 12'h330; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      cnt_done = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done) cnt_done++;
      end
      chk("abort_done", cnt_done, 0);
      chk("abort_disp", $countones(display), 0);
      chk("abort_busy", busy, 0);
      chk("abort_coll", collision, 0);

      // start/clear while busy are dropped
      base = rd_cnt;
      @(negedge clk);
      vx = 8'd8; vy = 8'd2; n = 4'd3; i_reg = 12'h320; start = 1'b1;
      @(posedge clk);
      #1;
      vx = 8'd0; vy = 8'd0; n = 4'd1; i_reg = 12'h300; clear = 1'b1;
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (k == 2) begin
            start = 1'b0;
            clear = 1'b0;
         end
         if (done) begin
            lat = k;
            break;
         end
      end
      exp_disp = '0;
      set_px(8, 2);  set_px(15, 2);
      set_px(9, 3);  set_px(14, 3);
      set_px(10, 4); set_px(13, 4);
      chk("ign_latency", lat, 7);
      chk("ign_disp", $countones(display ^ exp_disp), 0);
      chk("ign_reads", rd_cnt - base, 3);
      chk("ign_addr2", rd_log[(base + 2) & 255], 12'h322);
      cnt_done = 0;
      cnt_busy = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (done) cnt_done++;
         if (busy) cnt_busy++;
      end
      chk("ign_no_requeue_done", cnt_done, 0);
      chk("ign_no_requeue_busy", cnt_busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
